// File: rtl/icache_pkg.sv
// icache_pkg: shared constants and types for the instruction cache.
//   ADDR_WIDTH / DATA_WIDTH : core-wide byte-address and instruction-word widths
//   icache_state_t          : controller state encoding, exported for debug visibility
package icache_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StMissReq,
        StRefill
    } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for the direct-mapped instruction cache.
//   clk           : clock, all writes on rising edge
//   clr_valid_i   : clear every valid bit (flush or reset); wins over a same-cycle valid write
//   rd_idx_i      : set index for the combinational read
//   rd_word_i     : word-in-line for the combinational read
//   rd_valid_o    : valid bit of the addressed set
//   rd_tag_o      : stored tag of the addressed set
//   rd_data_o     : addressed instruction word
//   wr_idx_i      : set index for writes
//   wr_word_i     : word-in-line for data writes
//   wr_data_en_i  : write wr_data_i into the addressed word
//   wr_data_i     : word to write
//   wr_tag_en_i   : write tag and valid bit of wr_idx_i
//   wr_tag_i      : tag to write
//   wr_valid_i    : valid bit to write with the tag
module icache_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 22,
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4,
    localparam int unsigned IDX_WIDTH  = $clog2(SETS),
    localparam int unsigned WORD_WIDTH = $clog2(LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  clr_valid_i,
    input  logic [IDX_WIDTH-1:0]  rd_idx_i,
    input  logic [WORD_WIDTH-1:0] rd_word_i,
    output logic                  rd_valid_o,
    output logic [TAG_WIDTH-1:0]  rd_tag_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic [IDX_WIDTH-1:0]  wr_idx_i,
    input  logic [WORD_WIDTH-1:0] wr_word_i,
    input  logic                  wr_data_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_tag_en_i,
    input  logic [TAG_WIDTH-1:0]  wr_tag_i,
    input  logic                  wr_valid_i
);

    logic [SETS-1:0]       valid_q;
    logic [TAG_WIDTH-1:0]  tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];

    // Only valid bits need a defined state; tag/data are never used while invalid.
    always_ff @(posedge clk) begin
        if (clr_valid_i) begin
            valid_q <= '0;
        end else if (wr_tag_en_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_tag_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
        if (wr_data_en_i) begin
            data_q[wr_idx_i][wr_word_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_word_i];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with one-cycle hit latency and
// word-per-beat line refill.
//   clk, rst      : clock; synchronous active-high reset
//   ifu_req_i     : fetch request valid
//   ifu_addr_i    : fetch byte address (bits [1:0] ignored)
//   ifu_ready_o   : request accepted when high together with ifu_req_i
//   ifu_rvalid_o  : single-cycle pulse, ifu_rdata_o valid
//   ifu_rdata_o   : instruction word, holds last value while ifu_rvalid_o is low
//   flush_i       : invalidate all lines (fence.i)
//   mem_req_o     : registered refill request, held until mem_gnt_i
//   mem_addr_o    : registered line-aligned refill address
//   mem_gnt_i     : refill request accepted
//   mem_rvalid_i  : refill beat valid (only observed in refill)
//   mem_rdata_i   : refill beat, ascending word order
// Optional build macro ICACHE_STATS_EN adds 32-bit hit_cnt_o / miss_cnt_o lookup counters.
module icache
    import icache_pkg::icache_state_t;
    import icache_pkg::StIdle;
    import icache_pkg::StLookup;
    import icache_pkg::StMissReq;
    import icache_pkg::StRefill;
#(
    parameter int unsigned ADDR_WIDTH = icache_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = icache_pkg::DATA_WIDTH,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned SETS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_i,
    input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
    output logic                  ifu_ready_o,
    output logic                  ifu_rvalid_o,
    output logic [DATA_WIDTH-1:0] ifu_rdata_o,
    input  logic                  flush_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    localparam int unsigned WORD_WIDTH = $clog2(LINE_WORDS);
    localparam int unsigned OFF_WIDTH  = WORD_WIDTH + 2;
    localparam int unsigned IDX_WIDTH  = $clog2(SETS);
    localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - OFF_WIDTH - IDX_WIDTH;

    icache_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] cnt_q, cnt_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [WORD_WIDTH-1:0] lk_word;
    logic [IDX_WIDTH-1:0]  lk_idx;
    logic [TAG_WIDTH-1:0]  lk_tag;

    logic                  arr_valid;
    logic [TAG_WIDTH-1:0]  arr_tag;
    logic [DATA_WIDTH-1:0] arr_data;

    logic                  hit;
    logic                  last_beat;
    logic                  wr_data_en;
    logic                  wr_tag_en;
    logic                  wr_valid;

    // Byte-select bits of the fetch address carry no information for word fetches.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_q[1:0];

    // The latched address drives both lookup and refill, so one index serves both.
    assign lk_word = addr_q[OFF_WIDTH-1:2];
    assign lk_idx  = addr_q[OFF_WIDTH+IDX_WIDTH-1:OFF_WIDTH];
    assign lk_tag  = addr_q[ADDR_WIDTH-1:OFF_WIDTH+IDX_WIDTH];

    icache_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk          (clk),
        .clr_valid_i  (rst | flush_i),
        .rd_idx_i     (lk_idx),
        .rd_word_i    (lk_word),
        .rd_valid_o   (arr_valid),
        .rd_tag_o     (arr_tag),
        .rd_data_o    (arr_data),
        .wr_idx_i     (lk_idx),
        .wr_word_i    (cnt_q),
        .wr_data_en_i (wr_data_en),
        .wr_data_i    (mem_rdata_i),
        .wr_tag_en_i  (wr_tag_en),
        .wr_tag_i     (lk_tag),
        .wr_valid_i   (wr_valid)
    );

    assign hit       = (state_q == StLookup) && arr_valid && (arr_tag == lk_tag);
    assign last_beat = (cnt_q == WORD_WIDTH'(LINE_WORDS - 1));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        rdata_d      = rdata_q;
        ifu_ready_o  = 1'b0;
        ifu_rvalid_o = 1'b0;
        wr_data_en   = 1'b0;
        wr_tag_en    = 1'b0;
        wr_valid     = 1'b0;

        unique case (state_q)
            StIdle: begin
                ifu_ready_o = 1'b1;
                if (ifu_req_i) begin
                    addr_d  = ifu_addr_i;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit) begin
                    ifu_rvalid_o = 1'b1;
                    ifu_ready_o  = 1'b1;
                    rdata_d      = arr_data;
                    if (ifu_req_i) begin
                        addr_d = ifu_addr_i;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {addr_q[ADDR_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
                    state_d    = StMissReq;
                end
            end
            StMissReq: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StRefill;
                end
            end
            StRefill: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    wr_data_en = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    if (last_beat) begin
                        // A flush seen at any point of the refill leaves the line invalid,
                        // forcing the re-lookup to refetch it.
                        wr_tag_en    = 1'b1;
                        wr_valid     = ~(flush_pend_q | flush_i);
                        flush_pend_d = 1'b0;
                        cnt_d        = '0;
                        state_d      = StLookup;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            rdata_q      <= rdata_d;
        end
    end

    // Hit data is forwarded straight from the array; otherwise the last word is held.
    assign ifu_rdata_o = hit ? arr_data : rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StLookup) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the fetch unit's instruction port and the instruction memory bus. It serves 32-bit instruction words to the fetch unit, with one-cycle latency on a hit. On a miss it refills a whole line from memory using a word-per-beat burst. It replaces the combinational instruction path into the core and adds a valid/ready handshake, so the fetch unit can stall on misses.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, instruction/bus word width
- LINE_WORDS, 4, words per line (power of two, ≥2)
- SETS, 16, number of lines (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req_i  in  1  fetch request valid
- ifu_addr_i  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- ifu_ready_o  out  1  request accepted this cycle when high with ifu_req_i
- ifu_rvalid_o  out  1  ifu_rdata_o valid, single-cycle pulse per request
- ifu_rdata_o  out  DATA_WIDTH  instruction word
- flush_i  in  1  invalidate all lines (fence.i)
- mem_req_o  out  1  line refill request, held until granted
- mem_addr_o  out  ADDR_WIDTH  line-aligned refill address
- mem_gnt_i  in  1  refill request accepted
- mem_rvalid_i  in  1  refill data beat valid
- mem_rdata_i  in  DATA_WIDTH  refill beat; beats arrive in ascending word order

## Operation
- Address split: offset = log2(LINE_WORDS)+2 LSBs; index = next log2(SETS) bits; tag = the remaining bits.
- State machine:
  - IDLE: ifu_ready_o=1. Request accepted → latch address → LOOKUP.
  - LOOKUP: compare the stored tag and valid bit at the latched index.
    - Hit: ifu_rvalid_o=1 and ifu_rdata_o=word[offset]. ifu_ready_o=1, so a new request may be accepted in the same cycle (stay in LOOKUP), otherwise → IDLE.
    - Miss: ifu_ready_o=0 → MISS_REQ.
  - MISS_REQ: mem_req_o=1, mem_addr_o = latched address with offset bits zeroed. On mem_gnt_i → REFILL with beat counter=0.
  - REFILL: each mem_rvalid_i writes data[index][counter] and increments the counter. After beat LINE_WORDS-1, write the tag and set valid (unless a flush is pending) → LOOKUP, which now hits.
- mem_rvalid_i is ignored outside REFILL.
- Flush:
  - flush_i clears all valid bits in the cycle it is sampled.
  - A flush during MISS_REQ or REFILL sets a pending flag. The refill still completes, but valid is not set and the flag clears, so the re-lookup misses and refetches.
  - A flush in the same cycle as a LOOKUP hit still returns the hit data.
- Reset: state=IDLE, all valid bits=0, beat counter=0, pending-flush flag=0. Outputs: ifu_ready_o=1 (IDLE), ifu_rvalid_o=0, ifu_rdata_o=0, mem_req_o=0, mem_addr_o=0.
- Reset mid-refill abandons the line. mem_req_o is low on the cycle after reset. Any remaining beats are ignored.

## Timing
- Hit latency: 1 cycle from acceptance to ifu_rvalid_o. Back-to-back hits sustain 1 word/cycle.
- Miss latency: 1 (LOOKUP) + grant wait (≥1) + LINE_WORDS beats (gaps allowed) + 1 (re-LOOKUP).
- mem_req_o and mem_addr_o are registered and stable from assertion until the cycle mem_gnt_i is sampled high.
- ifu_rdata_o holds its last value when ifu_rvalid_o=0.

## Configuration
- ICACHE_STATS_EN defined: adds output ports hit_cnt_o and miss_cnt_o (32 bits each).
  - They increment on LOOKUP hit, and on LOOKUP miss, respectively. A re-lookup after refill counts as a hit.
  - Both wrap at 2^32 and reset to 0.
- Undefined: neither the ports nor the counters exist. Behaviour is otherwise identical.

## Structure
- Shared package: ADDR_WIDTH/DATA_WIDTH constants (already global to the core) and the icache_state_t enum (IDLE, LOOKUP, MISS_REQ, REFILL) for debug visibility.
- Derived widths (offset/index/tag) are computed from parameters inside the block.
- One sub-module, icache_array: valid/tag/data storage with combinational read by index and a synchronous word write plus tag/valid write. It also has a clear-all-valid input driven by flush and reset.

## Test plan
- Cold miss at 0x8000_0000:
  - mem_addr_o=0x8000_0000; supply beats 0x00000013, 0x00100093, 0x00200113, 0x00300193.
  - → ifu_rdata_o=0x00000013 with rvalid; miss_cnt_o=1.
- Hits after that refill:
  - Back-to-back requests 0x8000_0004, 0x8000_0008, 0x8000_000C, no further mem_req_o.
  - → rdata 0x00100093, 0x00200113, 0x00300193 on consecutive cycles.
- Conflict:
  - Request 0x8000_0100 (same index 0) → miss and refill.
  - A following request to 0x8000_0000 misses again (line evicted).
- Flush during REFILL after beat 1: the refill completes and the re-lookup misses, issuing a second mem_req_o to the same address.
- Reset asserted in REFILL after 2 beats:
  - Next cycle: mem_req_o=0, ifu_rvalid_o=0.
  - Extra mem_rvalid_i beats are ignored.
  - A request to 0x8000_0000 misses.
- Grant stall: hold mem_gnt_i low for 5 cycles → mem_req_o and mem_addr_o stay constant and ifu_ready_o=0 throughout.
